doorlock_seq_fsm: RTL
=====================

# doorlock_seq_fsm

Parametrised door-lock sequencing controller. It replaces the fixed three-state idle/start/end sequencer. It sits between the debounced keypad-button pulses (`ps_start`, `ps_end`) plus the code-compare result (`match`) and the lock actuator and alarm drivers. Compared with its predecessor it adds:
- an entry timeout;
- a deny state;
- a failure counter with lockout;
- per-state programmable dwell times, sharing one parametrised timer.

## Interface
Parameters:
- `CNT_W`, 16: dwell-timer width. Every delay parameter must be ≥1 and ≤ 2^`CNT_W`−1.
- `ENTRY_TIMEOUT`, 5000: maximum cycles in ENTRY before abandoning to IDLE.
- `OPEN_DELAY`, 500: cycles the lock stays released.
- `DENY_DELAY`, 250: cycles of deny indication after a wrong code.
- `LOCKOUT_DELAY`, 20000: cycles of lockout after `MAX_FAIL` consecutive wrong codes.
- `MAX_FAIL`, 3: consecutive failures that trigger lockout. Must be ≥1 and ≤ 2^`FAIL_W`−1.
- `FAIL_W`, 3: width of the failure counter.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ps_start`  in  1  single-cycle start-entry pulse.
- `ps_end`  in  1  single-cycle end-entry pulse.
- `match`  in  1  code-compare result; sampled only in a cycle where `ps_end`=1.
- `state_out`  out  3  current state encoding.
- `unlock`  out  1  1 while in OPEN.
- `alarm`  out  1  1 while in LOCKOUT.
- `fail_cnt`  out  `FAIL_W`  consecutive wrong-code count.

## Operation
- States and encodings: IDLE=3'd0, ENTRY=3'd1, OPEN=3'd2, DENY=3'd3, LOCKOUT=3'd4. Encodings 5–7 are illegal and recover to IDLE on the next edge.
- Dwell timer `tmr`:
  - cleared on every edge where the state changes;
  - incremented otherwise;
  - cleared and held at 0 in IDLE.
- "Expire" means `tmr` == DELAY−1 for the current state.
- IDLE:
  - `ps_start` → ENTRY.
  - `ps_end` alone is ignored.
- ENTRY (priority in this order):
  1. `ps_end`&`match` → OPEN; `fail_cnt` cleared.
  2. `ps_end`&!`match`:
     - `fail_cnt`+1 == `MAX_FAIL` → LOCKOUT;
     - otherwise → DENY.
     - In both cases `fail_cnt` increments.
  3. `ps_start` → stay in ENTRY; `tmr` cleared (restart entry).
  4. `ENTRY_TIMEOUT` expire → IDLE. `fail_cnt` is unchanged.
- OPEN: expire at `OPEN_DELAY` → IDLE. `ps_start`/`ps_end` ignored.
- DENY: expire at `DENY_DELAY` → IDLE. Inputs ignored.
- LOCKOUT: expire at `LOCKOUT_DELAY` → IDLE, and `fail_cnt` cleared on the same edge. Inputs ignored.
- Simultaneous `ps_start`&`ps_end` in ENTRY: `ps_end` wins.
- `ps_end` on the same cycle as ENTRY timeout expiry: `ps_end` wins; the code is evaluated.
- `fail_cnt` saturates at `MAX_FAIL`; it never wraps.
- Outputs are decoded from the registered state only; no input-to-output combinational path.

## Timing
- Reset (async assert, sync release) sets:
  - `state_out`=0, `unlock`=0, `alarm`=0, `fail_cnt`=0, `tmr`=0.
- Reset asserted mid-operation aborts any state immediately, including OPEN/LOCKOUT.
- Latency: an input sampled at edge k is reflected on the outputs after edge k (1 cycle).
- Dwell: a timed state entered at edge k is left at edge k+DELAY. Outputs show the state for exactly DELAY cycles.
- ENTRY with no input is left at edge k+`ENTRY_TIMEOUT`.
- Pulses wider than one cycle are not supported. A held `ps_start` in ENTRY keeps restarting the timer.

## Structure
- Package `doorlock_pkg` holds:
  - the state encoding localparams/typedef (3 bits, values above);
  - the default delay constants, shared with other doorlock blocks.
- Sub-module `dwell_timer` (params `CNT_W`):
  - inputs `clr`, `limit`;
  - output `expire` (= `tmr`==`limit`−1 and not `clr`).
- The FSM selects `limit` by state.
- The FSM and the `fail_cnt` register live in `doorlock_seq_fsm`.

## Test plan
Bench parameters for every scenario: `ENTRY_TIMEOUT`=8, `OPEN_DELAY`=5, `DENY_DELAY`=3, `LOCKOUT_DELAY`=10, `MAX_FAIL`=3.

- Reset/open:
  - stimulus: reset; `ps_start`@c2; `ps_end`+`match`=1 @c4.
  - required: `state_out` 0→1 after c2, →2 after c4; `unlock`=1 for exactly 5 cycles; then `state_out`=0 and `fail_cnt`=0.
- Timeout:
  - stimulus: `ps_start`@c0, no further input.
  - required: ENTRY for exactly 8 cycles, then IDLE; `fail_cnt` unchanged.
- Timer restart and priority:
  - stimulus: `ps_start`@c0, `ps_start`@c6, then quiet.
  - required: IDLE only after c14.
  - stimulus: `ps_start`+`ps_end`+`match`=1 in the same ENTRY cycle.
  - required: OPEN.
- Lockout:
  - stimulus: three wrong codes (`ps_end`, `match`=0).
  - required: DENY for 3 cycles twice, with `fail_cnt` 1 then 2; third wrong code → `state_out`=4, `alarm`=1 for 10 cycles, `fail_cnt`=3; exit to IDLE with `fail_cnt`=0.
  - stimulus: `ps_start` during LOCKOUT.
  - required: ignored.
- Success clears failures:
  - stimulus: two wrong codes, then a correct code.
  - required: `fail_cnt` 2→0 on entry to OPEN.
- Async reset mid-OPEN:
  - stimulus: `rst`=0 at OPEN cycle 2.
  - required: `unlock`=0 and `state_out`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/doorlock_pkg.sv
// Shared doorlock definitions: sequencer state encoding and default dwell/fail constants.
package doorlock_pkg;

    localparam int unsigned ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_DENY    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam int unsigned DEF_CNT_W         = 16;
    localparam int unsigned DEF_ENTRY_TIMEOUT = 5000;
    localparam int unsigned DEF_OPEN_DELAY    = 500;
    localparam int unsigned DEF_DENY_DELAY    = 250;
    localparam int unsigned DEF_LOCKOUT_DELAY = 20000;
    localparam int unsigned DEF_MAX_FAIL      = 3;
    localparam int unsigned DEF_FAIL_W        = 3;

endpackage

// File: rtl/doorlock_seq_fsm_if.sv
// Keypad-side pulses and actuator/alarm status of the doorlock sequencer.
interface doorlock_seq_fsm_if
    import doorlock_pkg::*;
#(
    parameter int unsigned FAIL_W = DEF_FAIL_W
);
    logic              ps_start;
    logic              ps_end;
    logic              match;
    logic [ST_W-1:0]   state_out;
    logic              unlock;
    logic              alarm;
    logic [FAIL_W-1:0] fail_cnt;

    modport master (
        output ps_start, ps_end, match,
        input  state_out, unlock, alarm, fail_cnt
    );

    modport slave (
        input  ps_start, ps_end, match,
        output state_out, unlock, alarm, fail_cnt
    );
endinterface

// File: rtl/dwell_timer.sv
// Shared dwell counter: counts cycles in the current state, flags the last cycle before limit.
module dwell_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);
    logic [CNT_W-1:0] tmr;

    assign expire = !clr && (tmr == (limit - CNT_W'(1)));

    // Expiry always leaves the state, so it also restarts the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr <= '0;
        end else if (clr || expire) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + CNT_W'(1);
        end
    end
endmodule

// File: rtl/doorlock_seq_fsm.sv
// Door-lock sequencer: entry window, open/deny dwell, consecutive-failure lockout.
module doorlock_seq_fsm
    import doorlock_pkg::*;
#(
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned ENTRY_TIMEOUT = DEF_ENTRY_TIMEOUT,
    parameter int unsigned OPEN_DELAY    = DEF_OPEN_DELAY,
    parameter int unsigned DENY_DELAY    = DEF_DENY_DELAY,
    parameter int unsigned LOCKOUT_DELAY = DEF_LOCKOUT_DELAY,
    parameter int unsigned MAX_FAIL      = DEF_MAX_FAIL,
    parameter int unsigned FAIL_W        = DEF_FAIL_W
) (
    input  logic               clk,
    input  logic               rst,
    doorlock_seq_fsm_if.slave  bus
);
    localparam int unsigned CMP_W = FAIL_W + 1;
    localparam logic [CMP_W-1:0] MAX_FAIL_X = CMP_W'(MAX_FAIL);

    state_t            state;
    state_t            state_nxt;
    logic [FAIL_W-1:0] fail_q;
    logic [FAIL_W-1:0] fail_nxt;
    logic [CMP_W-1:0]  fail_inc;
    logic              unlock_q;
    logic              alarm_q;
    logic              timer_clr;
    logic              expire;
    logic [CNT_W-1:0]  limit;

    assign fail_inc = CMP_W'(fail_q) + CMP_W'(1);

    // Clear from state and inputs only, keeping expire free of any loop through the FSM
    assign timer_clr = (state == ST_IDLE) || (state > ST_LOCKOUT) ||
                       ((state == ST_ENTRY) && (bus.ps_start || bus.ps_end));

    always_comb begin
        limit = CNT_W'(ENTRY_TIMEOUT);
        case (state)
            ST_OPEN:    limit = CNT_W'(OPEN_DELAY);
            ST_DENY:    limit = CNT_W'(DENY_DELAY);
            ST_LOCKOUT: limit = CNT_W'(LOCKOUT_DELAY);
            default:    limit = CNT_W'(ENTRY_TIMEOUT);
        endcase
    end

    dwell_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .limit  (limit),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            fail_q   <= '0;
            unlock_q <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            fail_q   <= fail_nxt;
            unlock_q <= (state_nxt == ST_OPEN);
            alarm_q  <= (state_nxt == ST_LOCKOUT);
        end
    end

    always_comb begin
        state_nxt = state;
        fail_nxt  = fail_q;
        case (state)
            ST_IDLE: begin
                if (bus.ps_start) state_nxt = ST_ENTRY;
            end
            ST_ENTRY: begin
                // Code evaluation outranks restart and timeout
                if (bus.ps_end) begin
                    if (bus.match) begin
                        state_nxt = ST_OPEN;
                        fail_nxt  = '0;
                    end else begin
                        state_nxt = (fail_inc == MAX_FAIL_X) ? ST_LOCKOUT : ST_DENY;
                        fail_nxt  = (fail_inc > MAX_FAIL_X) ? fail_q : FAIL_W'(fail_inc);
                    end
                end else if (!bus.ps_start && expire) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_OPEN, ST_DENY: begin
                if (expire) state_nxt = ST_IDLE;
            end
            ST_LOCKOUT: begin
                if (expire) begin
                    state_nxt = ST_IDLE;
                    fail_nxt  = '0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.state_out = state;
    assign bus.unlock    = unlock_q;
    assign bus.alarm     = alarm_q;
    assign bus.fail_cnt  = fail_q;
endmodule
